// File: rtl/pxconv_pkg.sv
// pxconv_pkg
//   Shared by the pixel converter and the BRAM window reader.
//   Holds the default frame geometry, the grey pixel width, the reader FSM
//   state type and the 16-bit -> 8-bit grey saturation helper.
package pxconv_pkg;

  localparam int IMG_W     = 640;
  localparam int IMG_H     = 480;
  localparam int WND_ROWS  = 8;
  localparam int WND_DEPTH = WND_ROWS * IMG_W;
  localparam int GREY_W    = 8;

  typedef enum logic [1:0] {
    RD_IDLE     = 2'd0,
    RD_WAIT_ROW = 2'd1,
    RD_READ_ROW = 2'd2,
    RD_DRAIN    = 2'd3
  } rd_state_e;

  // Any grey value that does not fit in 8 bits clips to full white.
  function automatic logic [GREY_W-1:0] grey_sat(input logic [15:0] word);
    return (word[15:8] == 8'h00) ? word[GREY_W-1:0] : {GREY_W{1'b1}};
  endfunction

endpackage

// File: rtl/bram_wnd_reader_if.sv
// bram_wnd_reader_if
//   Bus bundle of the window reader: the BRAM read port (rd_en / rd_addr /
//   rd_data, one cycle read latency) and the outgoing pixel stream
//   (data / valid / ready plus sof / eol qualifiers).
//   master : the reader (drives the read port and the pixel stream)
//   slave  : the BRAM plus the downstream consumer
interface bram_wnd_reader_if #(
  parameter int ADDR_W = 32
);

  logic              bram_rd_en;
  logic [ADDR_W-1:0] bram_rd_addr;
  logic [31:0]       bram_rd_data;
  logic [7:0]        px_out_data;
  logic              px_out_valid;
  logic              px_out_ready;
  logic              px_out_sof;
  logic              px_out_eol;

  modport master (
    output bram_rd_en,
    output bram_rd_addr,
    input  bram_rd_data,
    output px_out_data,
    output px_out_valid,
    input  px_out_ready,
    output px_out_sof,
    output px_out_eol
  );

  modport slave (
    input  bram_rd_en,
    input  bram_rd_addr,
    output bram_rd_data,
    input  px_out_data,
    input  px_out_valid,
    output px_out_ready,
    input  px_out_sof,
    input  px_out_eol
  );

endinterface

// File: rtl/px_skid_buf.sv
// px_skid_buf
//   Two-entry FIFO that decouples the fixed-latency BRAM read pipe from a
//   stalling downstream consumer.
//   clk, rst_n         clock, asynchronous active-low reset (empties the buffer)
//   in_valid, in_data  write side; the producer only writes when count leaves room
//   out_valid          buffer non-empty
//   out_ready          consumer accepts when out_valid && out_ready
//   out_data           head entry, forced to 0 while empty
//   count              current occupancy (0..2), used by the producer for flow control
module px_skid_buf
  import pxconv_pkg::*;
#(
  parameter int PAYLOAD_W = GREY_W + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data,
  output logic [1:0]           count
);

  logic [PAYLOAD_W-1:0] mem [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           cnt;
  logic                 push;
  logic                 pop;

  // A write into a full buffer is dropped rather than overwriting the head.
  assign push      = in_valid && (cnt != 2'd2);
  assign out_valid = (cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  // Gating keeps data/flags at 0 while empty, including straight out of reset.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/bram_wnd_reader.sv
// bram_wnd_reader
//   Consumer end of the greyscale line-buffer BRAM ring. Once the converter
//   flags a full window, rows are read out of the ring one at a time, streamed
//   through a 2-entry skid buffer, and each fully accepted row is returned to
//   the converter as a pixel_ack pulse so that slot can be refilled.
//   clk, rst_n    clock, asynchronous active-low reset
//   wnd_in_bram   converter flag; its rising edge grants WND_ROWS row credits
//   row_wr_done   1-cycle pulse, grants one further row credit
//   bus           BRAM read port + pixel stream (master modport)
//   pixel_ack     1-cycle pulse after the eol pixel of a row is accepted
//   frame_done    1-cycle pulse after the last pixel of the frame is accepted
//   busy          FSM is not idle
module bram_wnd_reader
  import pxconv_pkg::*;
#(
  parameter int IMG_W    = pxconv_pkg::IMG_W,
  parameter int IMG_H    = pxconv_pkg::IMG_H,
  parameter int WND_ROWS = pxconv_pkg::WND_ROWS,
  parameter int ADDR_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wnd_in_bram,
  input  logic                     row_wr_done,
  bram_wnd_reader_if.master        bus,
  output logic                     pixel_ack,
  output logic                     frame_done,
  output logic                     busy
);

  localparam int COL_W      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W      = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CRED_W     = $clog2(WND_ROWS + 1);
  localparam int RING_DEPTH = WND_ROWS * IMG_W;

  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(WND_ROWS);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RING_DEPTH - 1);

  rd_state_e         state;
  logic [CRED_W-1:0] credits;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] rd_addr;
  logic              wnd_q;

  logic              rd_valid_q;
  logic              rd_sof_q;
  logic              rd_eol_q;

  logic              rd_en;
  logic              row_start;
  logic              wnd_rise;
  logic              pop;
  logic              eol_accept;
  logic [2:0]        in_use;
  logic [2:0]        capacity;

  logic [GREY_W+1:0] skid_in;
  logic [GREY_W+1:0] skid_out;
  logic              skid_valid;
  logic [1:0]        skid_count;

  // Only the low 16 bits of a BRAM word carry grey data.
  logic              unused_hi;
  assign unused_hi = &{1'b0, bus.bram_rd_data[31:16]};

  assign wnd_rise   = wnd_in_bram && !wnd_q;
  assign row_start  = (state == RD_WAIT_ROW) && (credits != '0);
  assign pop        = skid_valid && bus.px_out_ready;
  assign eol_accept = pop && skid_out[GREY_W];

  // A slot freed by this cycle's pop is counted as available, which is what
  // sustains one read per clock while the consumer keeps ready high.
  assign in_use   = {1'b0, skid_count} + {2'b00, rd_valid_q};
  assign capacity = 3'd2 + {2'b00, pop};
  assign rd_en    = (state == RD_READ_ROW) && (in_use < capacity);

  assign busy = (state != RD_IDLE);

  // FSM, credit counter, column/row counters, ring address and the one-deep
  // tag pipe that travels alongside the BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RD_IDLE;
      credits    <= '0;
      col        <= '0;
      row        <= '0;
      rd_addr    <= '0;
      wnd_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_sof_q   <= 1'b0;
      rd_eol_q   <= 1'b0;
      pixel_ack  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      wnd_q      <= wnd_in_bram;
      pixel_ack  <= 1'b0;
      frame_done <= 1'b0;

      rd_valid_q <= rd_en;
      rd_sof_q   <= rd_en && (col == '0) && (row == '0);
      rd_eol_q   <= rd_en && (col == COL_LAST);

      // The window flag reloads the full ring; a simultaneous grant and
      // consume cancel out.
      if (wnd_rise) begin
        credits <= CRED_MAX;
      end else if (row_wr_done && !row_start) begin
        if (credits != CRED_MAX) begin
          credits <= credits + CRED_W'(1);
        end
      end else if (!row_wr_done && row_start) begin
        credits <= credits - CRED_W'(1);
      end

      case (state)
        RD_IDLE: begin
          if (credits != '0) begin
            state <= RD_WAIT_ROW;
          end
        end

        RD_WAIT_ROW: begin
          if (credits != '0) begin
            col   <= '0;
            state <= RD_READ_ROW;
          end
        end

        RD_READ_ROW: begin
          if (rd_en) begin
            rd_addr <= (rd_addr == ADDR_LAST) ? '0 : rd_addr + ADDR_W'(1);
            if (col == COL_LAST) begin
              col   <= '0;
              state <= RD_DRAIN;
            end else begin
              col <= col + COL_W'(1);
            end
          end
        end

        RD_DRAIN: begin
          if (eol_accept) begin
            pixel_ack <= 1'b1;
            if (row == ROW_LAST) begin
              frame_done <= 1'b1;
              row        <= '0;
              state      <= RD_IDLE;
            end else begin
              row   <= row + ROW_W'(1);
              state <= RD_WAIT_ROW;
            end
          end
        end

        default: state <= RD_IDLE;
      endcase
    end
  end

  assign skid_in = {rd_sof_q, rd_eol_q, grey_sat(bus.bram_rd_data[15:0])};

  px_skid_buf #(
    .PAYLOAD_W (GREY_W + 2)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (rd_valid_q),
    .in_data   (skid_in),
    .out_valid (skid_valid),
    .out_ready (bus.px_out_ready),
    .out_data  (skid_out),
    .count     (skid_count)
  );

  assign bus.bram_rd_en   = rd_en;
  assign bus.bram_rd_addr = rd_addr;
  assign bus.px_out_valid = skid_valid;
  assign bus.px_out_sof   = skid_out[GREY_W+1];
  assign bus.px_out_eol   = skid_out[GREY_W];
  assign bus.px_out_data  = skid_out[GREY_W-1:0];

endmodule

// File: tb/tb_bram_wnd_reader.sv
// tb_bram_wnd_reader
//   Scoreboard bench for bram_wnd_reader on a reduced 16x10 frame with a
//   4-row ring (ring depth 64, frame 160 pixels, so the second frame starts
//   at ring address 32). The bench plays the BRAM and the downstream sink.
//   Every granted row pushes its pixels into an expected queue, computed from
//   the pixel's global index since reset: ring address = index mod depth,
//   sof = index mod frame == 0, eol = index mod width == width-1.
//   A negedge monitor pops and compares on each accepted pixel.
module tb_bram_wnd_reader;

  localparam int TW    = 16;
  localparam int TH    = 10;
  localparam int TR    = 4;
  localparam int DEPTH = TW * TR;
  localparam int FRAME = TW * TH;

  typedef struct {
    logic [7:0] data;
    bit         sof;
    bit         eol;
    bit         last;
  } exp_t;

  logic clk         = 1'b0;
  logic rst_n       = 1'b0;
  logic wnd_in_bram = 1'b0;
  logic row_wr_done = 1'b0;
  logic pixel_ack;
  logic frame_done;
  logic busy;

  bram_wnd_reader_if #(.ADDR_W(32)) bus ();

  bram_wnd_reader #(
    .IMG_W    (TW),
    .IMG_H    (TH),
    .WND_ROWS (TR),
    .ADDR_W   (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wnd_in_bram (wnd_in_bram),
    .row_wr_done (row_wr_done),
    .bus         (bus),
    .pixel_ack   (pixel_ack),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  logic [31:0] mem [DEPTH];

  int total_cnt   = 0;
  int pass_cnt    = 0;
  int pix_k       = 0;
  int rows_pushed = 0;
  int reads_issued = 0;
  int px_accepted  = 0;
  int acks_seen    = 0;
  int frames_seen  = 0;
  int cycle_cnt    = 0;
  int rd_first     = 0;
  int rd_row0_last = 0;
  bit ready_mode   = 1'b0;
  bit exp_ack      = 1'b0;
  bit exp_fd       = 1'b0;
  bit prev_stall   = 1'b0;
  logic [9:0] prev_payload = '0;

  // Reference grey conversion: anything at or above 256 clips to white.
  function automatic logic [7:0] refGrey(input logic [31:0] w);
    return (w[15:0] < 16'h0100) ? w[7:0] : 8'hFF;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic pushRows(input int n);
    exp_t e;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < TW; c++) begin
        e.data = refGrey(mem[pix_k % DEPTH]);
        e.sof  = (pix_k % FRAME) == 0;
        e.eol  = (pix_k % TW) == TW - 1;
        e.last = (pix_k % FRAME) == FRAME - 1;
        exp_q.push_back(e);
        pix_k++;
      end
      rows_pushed++;
    end
  endtask

  // rise_wnd=1: raise the window flag (grants TR rows); else one row_wr_done pulse.
  task automatic applyStimulus(input bit rise_wnd);
    if (rise_wnd) begin
      wnd_in_bram = 1'b1;
      pushRows(TR);
      @(posedge clk); #1;
    end else begin
      row_wr_done = 1'b1;
      pushRows(1);
      @(posedge clk); #1;
      row_wr_done = 1'b0;
    end
  endtask

  task automatic waitAcks(input int n, input int budget);
    int i = 0;
    while (acks_seen < n && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    checkOutput("acks_reached", 32'(acks_seen >= n), 32'd1);
  endtask

  // Downstream ready: held high, or a fair coin each cycle.
  initial begin
    bus.px_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.px_out_ready = ready_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // BRAM with a one-cycle read latency.
  always @(posedge clk) begin
    if (bus.bram_rd_en) begin
      bus.bram_rd_data <= mem[bus.bram_rd_addr % 32'(DEPTH)];
    end
  end

  // Monitor: samples at negedge, when all bench drives and DUT outputs are settled.
  always @(negedge clk) begin
    bit   hs;
    int   outstanding;
    exp_t e;
    if (!rst_n) begin
      reads_issued = 0;
      px_accepted  = 0;
      acks_seen    = 0;
      frames_seen  = 0;
      exp_ack      = 1'b0;
      exp_fd       = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      cycle_cnt++;
      hs = bus.px_out_valid && bus.px_out_ready;

      if (exp_ack || pixel_ack) checkOutput("pixel_ack", 32'(pixel_ack), 32'(exp_ack));
      if (exp_fd || frame_done) checkOutput("frame_done", 32'(frame_done), 32'(exp_fd));
      if (pixel_ack) acks_seen++;
      if (frame_done) frames_seen++;
      exp_ack = 1'b0;
      exp_fd  = 1'b0;

      if (prev_stall) begin
        checkOutput("hold_valid", 32'(bus.px_out_valid), 32'd1);
        checkOutput("hold_payload", 32'({bus.px_out_sof, bus.px_out_eol, bus.px_out_data}),
                    32'(prev_payload));
      end

      if (bus.bram_rd_en) begin
        checkOutput("rd_addr", bus.bram_rd_addr, 32'(reads_issued % DEPTH));
        if (reads_issued == 0) rd_first = cycle_cnt;
        if (reads_issued == TW - 1) rd_row0_last = cycle_cnt;
        outstanding = reads_issued + 1 - (px_accepted + int'(hs));
        checkOutput("skid_room", 32'(outstanding <= 2), 32'd1);
        reads_issued++;
      end

      if (hs) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("[TB] FAIL stray_pixel actual data=0x%0h required no pixel at %0t",
                   bus.px_out_data, $time);
        end else begin
          e = exp_q.pop_front();
          checkOutput("px_data", 32'(bus.px_out_data), 32'(e.data));
          checkOutput("px_sof", 32'(bus.px_out_sof), 32'(e.sof));
          checkOutput("px_eol", 32'(bus.px_out_eol), 32'(e.eol));
          exp_ack = e.eol;
          exp_fd  = e.last;
        end
        px_accepted++;
      end

      prev_stall   = bus.px_out_valid && !bus.px_out_ready;
      prev_payload = {bus.px_out_sof, bus.px_out_eol, bus.px_out_data};
    end
  end

  // Stimulus sequence.
  initial begin
    int guard;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 1) == 1) mem[i][15:8] = 8'h00;
    end
    mem[0] = 32'h0000_0123;
    mem[1] = 32'hABCD_0042;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_rd_en", 32'(bus.bram_rd_en), 32'd0);
    checkOutput("reset_rd_addr", bus.bram_rd_addr, 32'd0);
    checkOutput("reset_valid", 32'(bus.px_out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] first window, ready held high");
    applyStimulus(1'b1);
    waitAcks(TR, 2000);
    checkOutput("row0_read_span", 32'(rd_row0_last - rd_first), 32'(TW - 1));

    $display("[TB] credits exhausted, reader must stall");
    repeat (30) @(posedge clk);
    #1;
    checkOutput("stall_acks", 32'(acks_seen), 32'(TR));
    checkOutput("stall_busy", 32'(busy), 32'd1);
    checkOutput("stall_rd_en", 32'(bus.bram_rd_en), 32'd0);
    checkOutput("stall_addr_wrapped", bus.bram_rd_addr, 32'd0);
    checkOutput("stall_queue_empty", 32'(exp_q.size()), 32'd0);
    applyStimulus(1'b0);
    waitAcks(TR + 1, 2000);
    repeat (30) @(posedge clk);
    #1;
    checkOutput("one_more_row", 32'(acks_seen), 32'(TR + 1));

    $display("[TB] random ready across two frames");
    ready_mode = 1'b1;
    guard = 0;
    while (rows_pushed < 2 * TH && guard < 4000) begin
      if ((rows_pushed - acks_seen) < TR && $urandom_range(0, 3) == 0) begin
        applyStimulus(1'b0);
      end else begin
        @(posedge clk); #1;
      end
      guard++;
    end
    waitAcks(2 * TH, 4000);
    checkOutput("frames_done", 32'(frames_seen), 32'd2);
    checkOutput("frame_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] reset in the middle of a row");
    ready_mode = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b0);
    guard = 0;
    while (!(bus.bram_rd_en && reads_issued >= 2 * FRAME + 5) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("midrow_reached", 32'(guard < 200), 32'd1);
    @(posedge clk); #1;
    rst_n       = 1'b0;
    wnd_in_bram = 1'b0;
    #1;
    checkOutput("midrst_rd_en", 32'(bus.bram_rd_en), 32'd0);
    checkOutput("midrst_rd_addr", bus.bram_rd_addr, 32'd0);
    checkOutput("midrst_valid", 32'(bus.px_out_valid), 32'd0);
    checkOutput("midrst_payload", 32'({bus.px_out_sof, bus.px_out_eol, bus.px_out_data}), 32'd0);
    checkOutput("midrst_ack", 32'({pixel_ack, frame_done}), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pix_k       = 0;
    rows_pushed = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("post_rst_valid", 32'(bus.px_out_valid), 32'd0);
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    checkOutput("post_rst_reads", 32'(reads_issued), 32'd0);

    applyStimulus(1'b1);
    waitAcks(TR, 2000);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
